// File: rtl/mfp_spi_sensor_responder.sv
// SPI responder standing in for the light-sensor ADC: oversamples CS/SCK, shifts out {zeros, sample, zeros}.
// SDO updates SYNC_STAGES+2 clocks after an SCK fall pin edge; also reports frame done/abort/extra clocks.
module mfp_spi_sensor_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int LEAD_ZEROS  = 3,
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  SI_ClkIn,
  input  logic                  SI_Reset,
  input  logic                  SPI_CS,
  input  logic                  SPI_SCK,
  output logic                  SPI_SDO,
  input  logic [DATA_WIDTH-1:0] sample_value,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic                  extra_clk,
  output logic [15:0]           frame_count,
  output logic                  busy
);

  localparam int TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_WIDTH;
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic                   cs_prev;
  logic                   sck_prev;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sck_fall;
  logic [FRAME_BITS-1:0]  frame_word;
  logic [FRAME_BITS-1:0]  shreg;
  logic [CNT_W-1:0]       bit_cnt;

  // Leading zeros fall out of the zero-extension; trailing zeros come from the shift.
  assign frame_word = FRAME_BITS'(sample_value) << TRAIL_ZEROS;

  // Synchronizers idle high so reset release never looks like a CS or SCK fall.
  always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
    if (SI_Reset) begin
      cs_sync  <= '1;
      sck_sync <= '1;
      cs_prev  <= 1'b1;
      sck_prev <= 1'b1;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
      sck_fall <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], SPI_SCK};
      cs_prev  <= cs_sync[SYNC_STAGES-1];
      sck_prev <= sck_sync[SYNC_STAGES-1];
      cs_fall  <= cs_prev & ~cs_sync[SYNC_STAGES-1];
      cs_rise  <= ~cs_prev & cs_sync[SYNC_STAGES-1];
      sck_fall <= sck_prev & ~sck_sync[SYNC_STAGES-1];
    end
  end

  // shreg holds the bits still to be sent, MSB next; SDO carries the current bit.
  always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
    if (SI_Reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      frame_count <= '0;
      SPI_SDO     <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      extra_clk   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            shreg     <= frame_word << 1;
            SPI_SDO   <= frame_word[FRAME_BITS-1];
            bit_cnt   <= '0;
            extra_clk <= 1'b0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            frame_abort <= 1'b1;
            SPI_SDO     <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (sck_fall) begin
            if (bit_cnt == LAST_BIT) begin
              SPI_SDO     <= 1'b0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              busy        <= 1'b0;
              state       <= DONE;
            end else begin
              SPI_SDO <= shreg[FRAME_BITS-1];
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (cs_rise) begin
            state <= IDLE;
          end else if (sck_fall) begin
            extra_clk <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_spi_sensor_responder.sv
// Directed bench acting as the SPI master: SCK half-period of 8 clocks, SDO latched while SCK is high,
// just before each falling edge.
module tb_mfp_spi_sensor_responder;

  localparam int HP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        sck;
  logic        sdo;
  logic [7:0]  sval;
  logic        done;
  logic        abort;
  logic        extra;
  logic [15:0] fcount;
  logic        busy;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  mfp_spi_sensor_responder dut (
    .SI_ClkIn    (clk),
    .SI_Reset    (rst),
    .SPI_CS      (cs),
    .SPI_SCK     (sck),
    .SPI_SDO     (sdo),
    .sample_value(sval),
    .frame_done  (done),
    .frame_abort (abort),
    .extra_clk   (extra),
    .frame_count (fcount),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Counting high cycles means a pulse wider than one clock shows up as an extra count.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (abort) abort_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clocks(input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      rx = {rx[30:0], sdo};
      sck = 1'b0;
      tick(HP);
      sck = 1'b1;
      tick(HP);
    end
  endtask

  task automatic frame(input logic [7:0] v, output logic [15:0] rx);
    logic [31:0] r;
    sval = v;
    cs = 1'b0;
    tick(HP);
    clocks(16, r);
    rx = r[15:0];
    cs = 1'b1;
    tick(HP);
  endtask

  task automatic test_reset;
    rst = 1'b1; cs = 1'b1; sck = 1'b1; sval = 8'h00;
    tick(5);
    total++; if (sdo !== 1'b0) begin bad++; $display("FAIL reset_sdo got=%b want=0", sdo); end
    total++; if (fcount !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fcount); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0 || abort !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b want=00", done, abort); end
    total++; if (extra !== 1'b0) begin bad++; $display("FAIL reset_extra got=%b want=0", extra); end
    rst = 1'b0;
    tick(6);
    total++; if (busy !== 1'b0 || done_cnt != 0 || abort_cnt != 0) begin
      bad++; $display("FAIL reset_release got busy=%b done=%0d abort=%0d want 0/0/0", busy, done_cnt, abort_cnt);
    end
  endtask

  task automatic test_single_frame;
    logic [31:0] r;
    done_cnt = 0;
    sval = 8'hA5;
    cs = 1'b0;
    tick(HP);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
    sval = 8'h5A;
    clocks(16, r);
    total++; if (r[15:0] !== 16'h14A0) begin bad++; $display("FAIL single_data got=%h want=14a0", r[15:0]); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done got=%0d want=1", done_cnt); end
    total++; if (fcount !== 16'd1) begin bad++; $display("FAIL single_count got=%0d want=1", fcount); end
    total++; if (busy !== 1'b0 || sdo !== 1'b0) begin bad++; $display("FAIL single_end got busy=%b sdo=%b want 0/0", busy, sdo); end
    cs = 1'b1;
    tick(HP);
  endtask

  task automatic test_back_to_back;
    logic [15:0] rx;
    rst = 1'b1; cs = 1'b1; sck = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    done_cnt = 0;
    frame(8'h00, rx);
    total++; if (rx !== 16'h0000) begin bad++; $display("FAIL b2b_first got=%h want=0000", rx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_gap_busy got=%b want=0", busy); end
    frame(8'hFF, rx);
    total++; if (rx !== 16'h1FE0) begin bad++; $display("FAIL b2b_second got=%h want=1fe0", rx); end
    total++; if (fcount !== 16'd2) begin bad++; $display("FAIL b2b_count got=%0d want=2", fcount); end
    total++; if (done_cnt != 2) begin bad++; $display("FAIL b2b_done got=%0d want=2", done_cnt); end
  endtask

  task automatic test_abort;
    logic [31:0] r;
    logic [15:0] rx;
    done_cnt = 0;
    abort_cnt = 0;
    sval = 8'hFF;
    cs = 1'b0;
    tick(HP);
    clocks(7, r);
    cs = 1'b1;
    tick(HP);
    total++; if (abort_cnt != 1) begin bad++; $display("FAIL abort_pulse got=%0d want=1", abort_cnt); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_nodone got=%0d want=0", done_cnt); end
    total++; if (fcount !== 16'd2) begin bad++; $display("FAIL abort_count got=%0d want=2", fcount); end
    total++; if (sdo !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle got sdo=%b busy=%b want 0/0", sdo, busy); end
    frame(8'h3C, rx);
    total++; if (rx !== 16'h0780) begin bad++; $display("FAIL abort_next got=%h want=0780", rx); end
    total++; if (fcount !== 16'd3) begin bad++; $display("FAIL abort_next_count got=%0d want=3", fcount); end
  endtask

  task automatic test_extra_clk;
    logic [31:0] r;
    logic [31:0] r2;
    done_cnt = 0;
    sval = 8'h5A;
    cs = 1'b0;
    tick(HP);
    clocks(16, r);
    total++; if (r[15:0] !== 16'h0B40) begin bad++; $display("FAIL extra_data got=%h want=0b40", r[15:0]); end
    total++; if (done_cnt != 1 || extra !== 1'b0) begin bad++; $display("FAIL extra_at16 got done=%0d extra=%b want 1/0", done_cnt, extra); end
    clocks(2, r2);
    total++; if (r2[1:0] !== 2'b00) begin bad++; $display("FAIL extra_sdo got=%b want=00", r2[1:0]); end
    total++; if (extra !== 1'b1 || done_cnt != 1) begin bad++; $display("FAIL extra_set got extra=%b done=%0d want 1/1", extra, done_cnt); end
    cs = 1'b1;
    tick(HP);
    total++; if (extra !== 1'b1) begin bad++; $display("FAIL extra_sticky got=%b want=1", extra); end
    cs = 1'b0;
    tick(HP);
    total++; if (extra !== 1'b0) begin bad++; $display("FAIL extra_clear got=%b want=0", extra); end
    clocks(16, r);
    cs = 1'b1;
    tick(HP);
    total++; if (fcount !== 16'd5) begin bad++; $display("FAIL extra_count got=%0d want=5", fcount); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] r;
    logic [15:0] rx;
    sval = 8'hFF;
    cs = 1'b0;
    tick(HP);
    clocks(9, r);
    total++; if (sdo !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid_before got sdo=%b busy=%b want 1/1", sdo, busy); end
    rst = 1'b1;
    #1;
    total++; if (sdo !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_async got sdo=%b busy=%b want 0/0", sdo, busy); end
    total++; if (fcount !== 16'd0 || extra !== 1'b0) begin bad++; $display("FAIL mid_async_regs got count=%0d extra=%b want 0/0", fcount, extra); end
    cs = 1'b1; sck = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    done_cnt = 0;
    frame(8'h81, rx);
    total++; if (rx !== 16'h1020) begin bad++; $display("FAIL mid_next got=%h want=1020", rx); end
    total++; if (fcount !== 16'd1 || done_cnt != 1) begin bad++; $display("FAIL mid_next_count got count=%0d done=%0d want 1/1", fcount, done_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_abort();
    test_extra_clk();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
